// File: rtl/hazard_scoreboard_unit.sv
// Pipeline hazard unit: operand forwarding, load-use / long-op RAW / structural
// stalls, branch flushing and a per-register countdown scoreboard for the long unit.
module hazard_scoreboard_unit #(
  parameter int unsigned AW   = 5,
  parameter int unsigned NSRC = 2,
  parameter int unsigned LAT  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NSRC*AW-1:0]   Rs_D,
  input  logic [NSRC-1:0]      RsUse_D,
  input  logic                 LongOp_D,
  input  logic [NSRC*AW-1:0]   Rs_E,
  input  logic [AW-1:0]        RD_E,
  input  logic                 RegWriteE,
  input  logic                 LoadE,
  input  logic                 LongIssueE,
  input  logic                 PCSrcE,
  input  logic [AW-1:0]        RD_M,
  input  logic [AW-1:0]        RD_WB,
  input  logic                 RegWriteM,
  input  logic                 RegWriteW,
  output logic [2*NSRC-1:0]    ForwardE,
  output logic                 StallF,
  output logic                 StallD,
  output logic                 FlushD,
  output logic                 FlushE,
  output logic                 LongBusy,
  output logic [(2**AW)-1:0]   Pending
);

  localparam int unsigned NREG = 2 ** AW;
  localparam int unsigned CW   = $clog2(LAT + 1);
  localparam logic [CW-1:0] LAT_C = CW'(LAT);

  logic          rd_e_nz;
  logic          issue_wr;
  logic [CW-1:0] busy_cnt;
  logic          load_use;
  logic          long_raw;
  logic          struct_hz;
  logic          hazard;

  assign rd_e_nz  = (RD_E != '0);
  assign issue_wr = LongIssueE & RegWriteE & rd_e_nz;

  // Register 0 is hardwired and never tracked.
  assign Pending[0] = 1'b0;

  genvar r;
  generate
    for (r = 1; r < NREG; r++) begin : g_sb
      logic [CW-1:0] cnt;

      // A re-issue to the same register reloads even while counting down.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt <= '0;
        end else if (issue_wr && (RD_E == AW'(r))) begin
          cnt <= LAT_C;
        end else if (cnt != '0) begin
          cnt <= cnt - CW'(1);
        end
      end

      assign Pending[r] = (cnt != '0);
    end
  endgenerate

  // Occupancy of the non-pipelined long unit, independent of destination.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_cnt <= '0;
    end else if (LongIssueE) begin
      busy_cnt <= LAT_C;
    end else if (busy_cnt != '0) begin
      busy_cnt <= busy_cnt - CW'(1);
    end
  end

  assign LongBusy = (busy_cnt != '0);

  // Forward selection, M before WB.
  always_comb begin
    ForwardE = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (RegWriteM && (RD_M != '0) && (RD_M == Rs_E[i*AW +: AW])) begin
        ForwardE[2*i +: 2] = 2'b10;
      end else if (RegWriteW && (RD_WB != '0) && (RD_WB == Rs_E[i*AW +: AW])) begin
        ForwardE[2*i +: 2] = 2'b01;
      end
    end
  end

  // Decode-side hazard detection over all used sources.
  always_comb begin
    load_use = 1'b0;
    long_raw = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (RsUse_D[i]) begin
        if (LoadE && RegWriteE && rd_e_nz && (Rs_D[i*AW +: AW] == RD_E)) begin
          load_use = 1'b1;
        end
        if (Pending[Rs_D[i*AW +: AW]] || (issue_wr && (Rs_D[i*AW +: AW] == RD_E))) begin
          long_raw = 1'b1;
        end
      end
    end
  end

  assign struct_hz = LongOp_D & (LongBusy | LongIssueE);
  assign hazard    = load_use | long_raw | struct_hz;

  // A taken branch discards the stalled decode instruction, so it overrides stalls.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    if (PCSrcE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (hazard) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed-vector bench for hazard_scoreboard_unit (AW=5, NSRC=2, LAT=4).
module tb_hazard_scoreboard_unit;

  localparam int unsigned AW   = 5;
  localparam int unsigned NSRC = 2;
  localparam int unsigned LAT  = 4;

  logic                clk;
  logic                rst;
  logic [NSRC*AW-1:0]  Rs_D;
  logic [NSRC-1:0]     RsUse_D;
  logic                LongOp_D;
  logic [NSRC*AW-1:0]  Rs_E;
  logic [AW-1:0]       RD_E;
  logic                RegWriteE;
  logic                LoadE;
  logic                LongIssueE;
  logic                PCSrcE;
  logic [AW-1:0]       RD_M;
  logic [AW-1:0]       RD_WB;
  logic                RegWriteM;
  logic                RegWriteW;
  logic [2*NSRC-1:0]   ForwardE;
  logic                StallF;
  logic                StallD;
  logic                FlushD;
  logic                FlushE;
  logic                LongBusy;
  logic [(2**AW)-1:0]  Pending;

  int checks;
  int failures;

  hazard_scoreboard_unit #(.AW(AW), .NSRC(NSRC), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .Rs_D(Rs_D), .RsUse_D(RsUse_D), .LongOp_D(LongOp_D),
    .Rs_E(Rs_E), .RD_E(RD_E), .RegWriteE(RegWriteE), .LoadE(LoadE),
    .LongIssueE(LongIssueE), .PCSrcE(PCSrcE),
    .RD_M(RD_M), .RD_WB(RD_WB), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ForwardE(ForwardE), .StallF(StallF), .StallD(StallD),
    .FlushD(FlushD), .FlushE(FlushE), .LongBusy(LongBusy), .Pending(Pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    Rs_D = '0; RsUse_D = '0; LongOp_D = 1'b0; Rs_E = '0; RD_E = '0;
    RegWriteE = 1'b0; LoadE = 1'b0; LongIssueE = 1'b0; PCSrcE = 1'b0;
    RD_M = '0; RD_WB = '0; RegWriteM = 1'b0; RegWriteW = 1'b0;
  endtask

  // Let any previous long op drain before the next scenario.
  task automatic idle(input int n);
    clear_inputs();
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    #3;
    checks++;
    if ({ForwardE, StallF, StallD, FlushD, FlushE, LongBusy} !== 9'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b expected 000000000",
               {ForwardE, StallF, StallD, FlushD, FlushE, LongBusy});
    end
    checks++;
    if (Pending !== '0) begin
      failures++;
      $display("FAIL reset_pending: got %h expected 0", Pending);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_forward();
    idle(1);
    RD_M = 5'd5; RegWriteM = 1'b1; RD_WB = 5'd5; RegWriteW = 1'b1;
    Rs_E = {5'd5, 5'd5};
    #1;
    checks++;
    if (ForwardE !== 4'b1010) begin
      failures++;
      $display("FAIL fwd_m_priority: got %b expected 1010", ForwardE);
    end
    RD_M = 5'd0;
    #1;
    checks++;
    if (ForwardE !== 4'b0101) begin
      failures++;
      $display("FAIL fwd_wb_when_rdm0: got %b expected 0101", ForwardE);
    end
    RD_M = 5'd5; RD_WB = 5'd6; Rs_E = {5'd6, 5'd5};
    #1;
    checks++;
    if (ForwardE !== 4'b0110) begin
      failures++;
      $display("FAIL fwd_mixed: got %b expected 0110", ForwardE);
    end
    RegWriteM = 1'b0; RegWriteW = 1'b0;
    #1;
    checks++;
    if (ForwardE !== 4'b0000) begin
      failures++;
      $display("FAIL fwd_no_write: got %b expected 0000", ForwardE);
    end
    RD_WB = 5'd0; RegWriteW = 1'b1; Rs_E = {5'd0, 5'd0};
    #1;
    checks++;
    if (ForwardE !== 4'b0000) begin
      failures++;
      $display("FAIL fwd_reg0: got %b expected 0000", ForwardE);
    end
  endtask

  task automatic test_load_use();
    idle(1);
    LoadE = 1'b1; RegWriteE = 1'b1; RD_E = 5'd7; Rs_D = {5'd7, 5'd2}; RsUse_D = 2'b10;
    #1;
    checks++;
    if ({StallF, StallD, FlushD, FlushE} !== 4'b1101) begin
      failures++;
      $display("FAIL load_use_stall: got %b expected 1101", {StallF, StallD, FlushD, FlushE});
    end
    RsUse_D = 2'b00;
    #1;
    checks++;
    if ({StallF, StallD, FlushD, FlushE} !== 4'b0000) begin
      failures++;
      $display("FAIL load_use_unused: got %b expected 0000", {StallF, StallD, FlushD, FlushE});
    end
    RD_E = 5'd0; Rs_D = {5'd0, 5'd0}; RsUse_D = 2'b11;
    #1;
    checks++;
    if ({StallF, StallD, FlushD, FlushE} !== 4'b0000) begin
      failures++;
      $display("FAIL load_use_reg0: got %b expected 0000", {StallF, StallD, FlushD, FlushE});
    end
  endtask

  task automatic test_long_raw();
    idle(6);
    LongIssueE = 1'b1; RegWriteE = 1'b1; RD_E = 5'd9;
    #1;
    checks++;
    if ({LongBusy, Pending[9]} !== 2'b00) begin
      failures++;
      $display("FAIL raw_c0_state: got %b expected 00", {LongBusy, Pending[9]});
    end
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      clear_inputs();
      Rs_D = {5'd0, 5'd9}; RsUse_D = 2'b01;
      #1;
      checks++;
      if ({Pending[9], LongBusy, StallF, StallD, FlushD, FlushE} !== 6'b111101) begin
        failures++;
        $display("FAIL raw_c%0d: got %b expected 111101", c,
                 {Pending[9], LongBusy, StallF, StallD, FlushD, FlushE});
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if ({Pending[9], LongBusy, StallF, StallD, FlushD, FlushE} !== 6'b000000) begin
      failures++;
      $display("FAIL raw_c5_release: got %b expected 000000",
               {Pending[9], LongBusy, StallF, StallD, FlushD, FlushE});
    end
  endtask

  task automatic test_structural();
    idle(6);
    LongIssueE = 1'b1; RegWriteE = 1'b0; RD_E = 5'd12; LongOp_D = 1'b1;
    #1;
    checks++;
    if ({StallF, StallD, FlushD, FlushE} !== 4'b1101) begin
      failures++;
      $display("FAIL struct_c0_issue: got %b expected 1101", {StallF, StallD, FlushD, FlushE});
    end
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      clear_inputs();
      LongOp_D = 1'b1;
      #1;
      checks++;
      if ({LongBusy, StallF, StallD, FlushD, FlushE} !== 5'b11101 || Pending !== '0) begin
        failures++;
        $display("FAIL struct_c%0d: got %b pend %h expected 11101 pend 0", c,
                 {LongBusy, StallF, StallD, FlushD, FlushE}, Pending);
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if ({LongBusy, StallF, StallD, FlushD, FlushE} !== 5'b00000) begin
      failures++;
      $display("FAIL struct_c5_release: got %b expected 00000",
               {LongBusy, StallF, StallD, FlushD, FlushE});
    end
  endtask

  task automatic test_waw_reissue();
    idle(6);
    LongIssueE = 1'b1; RegWriteE = 1'b1; RD_E = 5'd4; Rs_D = {5'd4, 5'd0}; RsUse_D = 2'b10;
    #1;
    checks++;
    if ({StallF, FlushE} !== 2'b11) begin
      failures++;
      $display("FAIL waw_same_cycle_raw: got %b expected 11", {StallF, FlushE});
    end
    @(negedge clk);
    clear_inputs();
    @(negedge clk);
    LongIssueE = 1'b1; RegWriteE = 1'b1; RD_E = 5'd4;
    @(negedge clk);
    clear_inputs();
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (Pending[4] !== 1'b1) begin
      failures++;
      $display("FAIL waw_c6_pending: got %b expected 1", Pending[4]);
    end
    @(negedge clk);
    #1;
    checks++;
    if (Pending[4] !== 1'b0) begin
      failures++;
      $display("FAIL waw_c7_clear: got %b expected 0", Pending[4]);
    end
  endtask

  task automatic test_branch();
    idle(1);
    LoadE = 1'b1; RegWriteE = 1'b1; RD_E = 5'd7; Rs_D = {5'd0, 5'd7}; RsUse_D = 2'b01;
    PCSrcE = 1'b1;
    #1;
    checks++;
    if ({StallF, StallD, FlushD, FlushE} !== 4'b0011) begin
      failures++;
      $display("FAIL branch_override: got %b expected 0011", {StallF, StallD, FlushD, FlushE});
    end
    clear_inputs();
    PCSrcE = 1'b1;
    #1;
    checks++;
    if ({StallF, StallD, FlushD, FlushE} !== 4'b0011) begin
      failures++;
      $display("FAIL branch_alone: got %b expected 0011", {StallF, StallD, FlushD, FlushE});
    end
  endtask

  task automatic test_reset_mid_op();
    idle(6);
    LongIssueE = 1'b1; RegWriteE = 1'b1; RD_E = 5'd3;
    @(negedge clk);
    clear_inputs();
    Rs_D = {5'd0, 5'd3}; RsUse_D = 2'b01;
    #1;
    checks++;
    if ({Pending[3], StallF} !== 2'b11) begin
      failures++;
      $display("FAIL rstmid_c1_stall: got %b expected 11", {Pending[3], StallF});
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({Pending[3], LongBusy, StallF, StallD, FlushE} !== 5'b00000) begin
      failures++;
      $display("FAIL rstmid_async_clear: got %b expected 00000",
               {Pending[3], LongBusy, StallF, StallD, FlushE});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({Pending[3], LongBusy, StallF, StallD, FlushE} !== 5'b00000) begin
        failures++;
        $display("FAIL rstmid_after_%0d: got %b expected 00000", c,
                 {Pending[3], LongBusy, StallF, StallD, FlushE});
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_forward();
    test_load_use();
    test_long_raw();
    test_structural();
    test_waw_reissue();
    test_branch();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
